// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift left / shift right / parallel load)
// advanced by an internal clock-enable divider, with word framing and an LED square wave.
module univ_shift_reg #(
    parameter int WIDTH = 4,
    parameter int DIV   = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] pin,
    output logic             s_out,
    output logic [WIDTH-1:0] pout,
    output logic             tick,
    output logic             word_done,
    output logic             ref_clk
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_LEFT  = 2'b01;
    localparam logic [1:0] MODE_RIGHT = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [CW-1:0]    div_cnt_q, div_cnt_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             dir_r_q, dir_r_d;
    logic             ref_clk_q, ref_clk_d;
    logic             word_done_q, word_done_d;
    logic             shift_en;

    assign tick = en && (div_cnt_q == DIV_LAST);

    always_comb begin
        div_cnt_d   = div_cnt_q;
        sreg_d      = sreg_q;
        bit_cnt_d   = bit_cnt_q;
        dir_r_d     = dir_r_q;
        ref_clk_d   = ref_clk_q;
        word_done_d = 1'b0;
        shift_en    = 1'b0;

        if (tick) begin
            div_cnt_d = '0;
            ref_clk_d = ~ref_clk_q;
            case (mode)
                MODE_LEFT: begin
                    sreg_d   = {sreg_q[WIDTH-2:0], sin};
                    dir_r_d  = 1'b0;
                    shift_en = 1'b1;
                end
                MODE_RIGHT: begin
                    sreg_d   = {sin, sreg_q[WIDTH-1:1]};
                    dir_r_d  = 1'b1;
                    shift_en = 1'b1;
                end
                MODE_LOAD: begin
                    sreg_d    = pin;
                    bit_cnt_d = '0;
                end
                MODE_HOLD: ;
                default: ;
            endcase
        end else if (en) begin
            div_cnt_d = div_cnt_q + 1'b1;
        end

        // Framing counter keeps running across direction changes; only load/reset re-frame.
        if (shift_en) begin
            if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_d   = '0;
                word_done_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q   <= '0;
            sreg_q      <= '0;
            bit_cnt_q   <= '0;
            dir_r_q     <= 1'b0;
            ref_clk_q   <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            sreg_q      <= sreg_d;
            bit_cnt_q   <= bit_cnt_d;
            dir_r_q     <= dir_r_d;
            ref_clk_q   <= ref_clk_d;
            word_done_q <= word_done_d;
        end
    end

    assign s_out     = dir_r_q ? sreg_q[0] : sreg_q[WIDTH-1];
    assign pout      = sreg_q;
    assign word_done = word_done_q;
    assign ref_clk   = ref_clk_q;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=4, DIV=4): directed scenarios plus a random run,
// all checked against an arithmetic reference model of the shift register.
module tb_univ_shift_reg;
    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         sin = 1'b0;
    logic [W-1:0] pin = '0;
    logic         s_out, tick, word_done, ref_clk;
    logic [W-1:0] pout;

    univ_shift_reg #(.WIDTH(W), .DIV(D)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sin(sin), .pin(pin),
        .s_out(s_out), .pout(pout), .tick(tick), .word_done(word_done), .ref_clk(ref_clk)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // reference model state (plain integers)
    int m_div = 0, m_sreg = 0, m_shifts = 0, m_dir = 0, m_ref = 0, m_wd = 0;
    logic m_tick, obs_tick;

    function automatic int exp_sout();
        return (m_dir != 0) ? (m_sreg % 2) : (m_sreg / (1 << (W - 1)));
    endfunction

    // drive one clock: inputs applied, tick sampled before the edge, model advanced, settle
    task automatic step(input logic r, input logic e, input logic [1:0] md,
                        input logic s, input logic [W-1:0] p);
        rst = r; en = e; mode = md; sin = s; pin = p;
        #1;
        obs_tick = tick;
        m_tick = e && (m_div == D - 1);
        @(posedge clk);
        if (r) begin
            m_div = 0; m_sreg = 0; m_shifts = 0; m_dir = 0; m_ref = 0; m_wd = 0;
        end else begin
            m_wd = 0;
            if (m_tick) begin
                m_div = 0;
                m_ref = 1 - m_ref;
                if (md == 2'b01) begin
                    m_sreg = (m_sreg * 2 + int'(s)) % (1 << W);
                    m_dir = 0; m_shifts++; m_wd = (m_shifts % W == 0);
                end else if (md == 2'b10) begin
                    m_sreg = m_sreg / 2 + int'(s) * (1 << (W - 1));
                    m_dir = 1; m_shifts++; m_wd = (m_shifts % W == 0);
                end else if (md == 2'b11) begin
                    m_sreg = int'(p); m_shifts = 0;
                end
            end else if (e) begin
                m_div++;
            end
        end
        #1;
    endtask

    // random junk between ticks, requested values on the tick cycle itself
    task automatic do_tick(input logic [1:0] md, input logic s, input logic [W-1:0] p);
        int guard = 0;
        while (m_div != D - 1 && guard < 2 * D) begin
            step(0, 1, 2'($urandom), 1'($urandom), W'($urandom));
            guard++;
        end
        step(0, 1, md, s, p);
        n_checks++;
        if (obs_tick !== 1'b1) begin
            n_fail++; $display("FAIL tick_expected got=%b want=1 (waited %0d)", obs_tick, guard);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1, 1'($urandom), 2'($urandom), 1'($urandom), W'($urandom));
        n_checks++;
        if (pout !== 4'b0000 || ref_clk !== 1'b0 || word_done !== 1'b0 || s_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_state pout=%b ref=%b wd=%b sout=%b want 0000/0/0/0",
                               pout, ref_clk, word_done, s_out);
        end
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 2'b00, 1'($urandom), W'($urandom));
            n_checks++;
            if (obs_tick !== ((i % 4) == 3)) begin
                n_fail++; $display("FAIL reset_tick_period clk%0d got=%b want=%b", i + 1, obs_tick, (i % 4) == 3);
            end
            n_checks++;
            if (ref_clk !== 1'(((i + 1) / 4) % 2)) begin
                n_fail++; $display("FAIL reset_ref_clk clk%0d got=%b want=%0d", i + 1, ref_clk, ((i + 1) / 4) % 2);
            end
        end
    endtask

    task automatic test_siso_left();
        logic [3:0] sins = 4'b1011;
        logic [3:0] souts = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            do_tick(2'b01, sins[3 - i], W'($urandom));
            n_checks++;
            if (s_out !== souts[3 - i] || int'(s_out) != exp_sout()) begin
                n_fail++; $display("FAIL siso_sout tick%0d got=%b want=%b", i + 1, s_out, souts[3 - i]);
            end
            n_checks++;
            if (word_done !== (i == 3) || int'(word_done) != m_wd) begin
                n_fail++; $display("FAIL siso_word_done tick%0d got=%b want=%b", i + 1, word_done, i == 3);
            end
        end
        n_checks++;
        if (pout !== 4'b1011) begin
            n_fail++; $display("FAIL siso_pout got=%b want=1011", pout);
        end
        step(0, 1, 2'b00, 0, 0);
        n_checks++;
        if (word_done !== 1'b0) begin
            n_fail++; $display("FAIL siso_wd_one_clk got=%b want=0", word_done);
        end
    endtask

    task automatic test_shift_right();
        do_tick(2'b10, 1'b0, W'($urandom));
        n_checks++;
        if (pout !== 4'b0101 || s_out !== 1'b1) begin
            n_fail++; $display("FAIL shift_right pout=%b sout=%b want 0101/1", pout, s_out);
        end
    endtask

    task automatic test_load_piso();
        logic [3:0] souts = 4'b0010;
        do_tick(2'b11, 1'($urandom), 4'b1001);
        n_checks++;
        if (pout !== 4'b1001 || word_done !== 1'b0) begin
            n_fail++; $display("FAIL load_pout pout=%b wd=%b want 1001/0", pout, word_done);
        end
        for (int i = 0; i < 4; i++) begin
            do_tick(2'b01, 1'b0, W'($urandom));
            n_checks++;
            if (s_out !== souts[3 - i] || word_done !== (i == 3) || int'(word_done) != m_wd) begin
                n_fail++; $display("FAIL piso tick%0d sout=%b wd=%b want %b/%b",
                                   i + 1, s_out, word_done, souts[3 - i], i == 3);
            end
        end
    endtask

    task automatic test_en_gating();
        logic         ref_hold;
        logic [W-1:0] pout_hold;
        int guard = 0;
        while (m_div != 2 && guard < 2 * D) begin step(0, 1, 2'b00, 0, 0); guard++; end
        ref_hold = ref_clk; pout_hold = pout;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 2'($urandom), 1'($urandom), W'($urandom));
            n_checks++;
            if (obs_tick !== 1'b0 || ref_clk !== ref_hold || pout !== pout_hold) begin
                n_fail++; $display("FAIL en_gating clk%0d tick=%b ref=%b pout=%b want 0/%b/%b",
                                   i, obs_tick, ref_clk, pout, ref_hold, pout_hold);
            end
        end
        step(0, 1, 2'b00, 0, 0);
        n_checks++;
        if (obs_tick !== 1'b0) begin
            n_fail++; $display("FAIL en_resume_first got=%b want=0", obs_tick);
        end
        step(0, 1, 2'b00, 0, 0);
        n_checks++;
        if (obs_tick !== 1'b1 || ref_clk === ref_hold) begin
            n_fail++; $display("FAIL en_resume_tick tick=%b ref=%b want 1/%b", obs_tick, ref_clk, ~ref_hold);
        end
    endtask

    task automatic test_reset_mid_word();
        int n;
        do_tick(2'b11, 0, 4'b0000);
        do_tick(2'b01, 1, 0);
        do_tick(2'b01, 1, 0);
        step(1, 1'($urandom), 2'($urandom), 1'($urandom), W'($urandom));
        n_checks++;
        if (pout !== 4'b0000 || ref_clk !== 1'b0) begin
            n_fail++; $display("FAIL midword_reset pout=%b ref=%b want 0000/0", pout, ref_clk);
        end
        for (int i = 0; i < 4; i++) begin
            do_tick(i[0] ? 2'b10 : 2'b01, 1'($urandom), 0);
            n_checks++;
            if (word_done !== (i == 3) || int'(word_done) != m_wd) begin
                n_fail++; $display("FAIL midword_wd shift%0d got=%b want=%b", i + 1, word_done, i == 3);
            end
        end
        // rst + tick collision, arranged so the tick alone would raise ref_clk
        if (m_ref != 0) do_tick(2'b00, 0, 0);
        n = 0;
        while (m_div != D - 1 && n < 2 * D) begin step(0, 1, 2'b00, 0, 0); n++; end
        step(1, 1, 2'b01, 1, 4'b1111);
        n_checks++;
        if (obs_tick !== 1'b1 || ref_clk !== 1'b0 || pout !== 4'b0000) begin
            n_fail++; $display("FAIL collision tick=%b ref=%b pout=%b want 1/0/0000", obs_tick, ref_clk, pout);
        end
        n = 0;
        obs_tick = 1'b0;
        while (obs_tick !== 1'b1 && n < 3 * D) begin step(0, 1, 2'b00, 0, 0); n++; end
        n_checks++;
        if (n != 4) begin
            n_fail++; $display("FAIL collision_next_tick clk=%0d want=4", n);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 40) == 0, ($urandom % 6) != 0, 2'($urandom), 1'($urandom), W'($urandom));
            n_checks++;
            if (obs_tick !== m_tick || int'(pout) != m_sreg || int'(s_out) != exp_sout()
                || int'(word_done) != m_wd || int'(ref_clk) != m_ref) begin
                n_fail++;
                $display("FAIL random cyc%0d tick=%b/%b pout=%b/%0d sout=%b/%0d wd=%b/%0d ref=%b/%0d",
                         i, obs_tick, m_tick, pout, m_sreg, s_out, exp_sout(), word_done, m_wd, ref_clk, m_ref);
            end
        end
    endtask

    initial begin
        test_reset();
        test_siso_left();
        test_shift_right();
        test_load_piso();
        test_en_gating();
        test_reset_mid_word();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
